msu_audio_fifo: RTL
===================

MSU_AUDIO_FIFO -- requirements
Module: msu_audio_fifo

Interface
REQ-001 Parameter CLK_HZ, default 21477270, system clock frequency in Hz.
REQ-002 Parameter SAMPLE_HZ, default 44100, output stereo frame rate in Hz.
REQ-003 Parameter FIFO_DEPTH, default 2048, sample FIFO depth in 16-bit words.
REQ-004 clk  in  1  system clock; the block has this one clock only.
REQ-005 reset  in  1  reset, asynchronous and active-high.
REQ-006 trackmounting  in  1  high while a new track is mounted; flushes the FIFO.
REQ-007 flush  in  1  single-cycle pulse; empties the FIFO on play start.
REQ-008 sd_ack_1  in  1  sector transfer in progress.
REQ-009 sd_buff_wr  in  1  a word is valid on sd_buff_dout.
REQ-010 sd_buff_dout  in  16  little-endian PCM word from the SD buffer.
REQ-011 sd_lba_1  in  21  sector currently being transferred.
REQ-012 ignore_sd_buffer_out  in  1  discard the current word (loop-offset skip).
REQ-013 audio_play  in  1  playback enabled.
REQ-014 volume  in  8  linear volume, 0 = mute, 255 = full scale.
REQ-015 audio_fifo_usedw  out  12  FIFO occupancy in words.
REQ-016 audio_l  out  16  signed left sample.
REQ-017 audio_r  out  16  signed right sample.
REQ-018 sample_strobe  out  1  single-cycle pulse when audio_l and audio_r update.
REQ-019 underrun  out  1  single-cycle pulse when a frame is due and fewer than 2 words are buffered.
REQ-020 overflow  out  1  sticky flag: a write was dropped because the FIFO was full.

Function
REQ-021 The word-in-sector counter (9 bits) SHALL clear on each sd_ack_1 rising edge and increment on every sd_buff_wr while sd_ack_1 is high.
REQ-022 A word SHALL be written only when all of the following hold: sd_ack_1 and sd_buff_wr are high; ignore_sd_buffer_out is low; the header condition (sd_lba_1==0 and word index <4) is false.
REQ-023 A write attempted while the FIFO is full SHALL be dropped and SHALL set overflow; overflow clears only on reset, flush or trackmounting.
REQ-024 The rate generator SHALL add SAMPLE_HZ to a 32-bit accumulator each clk; when the result is >= CLK_HZ it SHALL subtract CLK_HZ and emit an internal tick; it SHALL run regardless of audio_play.
REQ-025 Read FSM states: IDLE, POP_L, POP_R, SCALE, OUT.
REQ-026 IDLE -> POP_L on a tick when audio_play=1 and usedw>=2.
REQ-027 On a tick when audio_play=1 and usedw<2, the FSM SHALL stay in IDLE, pulse underrun, and leave audio_l and audio_r unchanged.
REQ-028 POP_L SHALL pop the left word; POP_R SHALL pop the right word; SCALE SHALL multiply; OUT SHALL register the outputs, pulse sample_strobe and return to IDLE.
REQ-029 Latency SHALL be exactly 4 clk from tick to sample_strobe; a tick arriving outside IDLE is lost (CLK_HZ >> SAMPLE_HZ makes this impossible in use).
REQ-030 On a tick when audio_play=0, audio_l and audio_r SHALL be driven to 0 with sample_strobe pulsed, and nothing SHALL be popped.
REQ-031 Simultaneous write and pop in one cycle SHALL both succeed; usedw SHALL be unchanged.
REQ-032 When flush or trackmounting is asserted, it SHALL override any write or pop in the same cycle: the FIFO empties, the FSM returns to IDLE, and the L/R pairing restarts with left.
REQ-033 Left/right pairing SHALL be positional (even word = left); flush is the only realignment.

Reset
REQ-034 On reset assertion, all outputs SHALL be 0, the FIFO empty, the accumulator 0, the FSM in IDLE, and the word counter 0.

Configuration
REQ-035 With MSU_AUDIO_VOLUME_EN defined, SCALE SHALL compute the signed 16 x unsigned 8 product (24 bits) and output bits [23:8] per channel.
REQ-036 Without MSU_AUDIO_VOLUME_EN, SCALE SHALL pass samples unmodified, volume SHALL be ignored, and latency SHALL stay 4 clk.

Structure
REQ-037 A shared package msu_pkg SHALL hold the FSM state enum, the header word count (4) and the sector size in words (256).
REQ-038 The FIFO SHALL be the sub-module msu_audio_sample_fifo (synchronous, FIFO_DEPTH x 16, usedw, clear input).

Verification
REQ-039 Sector 0 of 256 words 0..255 sent with audio_play=1 -> words 0-3 discarded, usedw=252, first strobe gives audio_l=4, audio_r=5.
REQ-040 FIFO holds 1 word and a tick occurs -> underrun pulses once, audio_l and audio_r keep their previous values, usedw stays 1.
REQ-041 2049 writes into an empty FIFO -> usedw=2048, overflow=1; flush -> usedw=0, overflow=0.
REQ-042 Volume 128 with L=0x4000, R=0x8000 -> audio_l=0x2000, audio_r=0xC000 (macro defined); 0x4000 and 0x8000 without the macro.
REQ-043 audio_play=0 for 10 ticks with 100 words buffered -> 10 strobes of zero output, usedw=100.
REQ-044 Reset asserted mid-POP_R -> all outputs 0 immediately; after release, the first strobe outputs the pair from freshly written data.

Source files
------------

// File: rtl/msu_pkg.sv
// ---------------------------------------------------------------------------
// msu_pkg
// Purpose : shared types and constants for the MSU audio sample path.
// Contents: read FSM state enum, stereo payload struct, sector/header sizes,
//           FIFO occupancy width.
// ---------------------------------------------------------------------------
package msu_pkg;

    localparam int unsigned SAMPLE_W     = 16;
    localparam int unsigned HDR_WORDS    = 4;
    localparam int unsigned SECTOR_WORDS = 256;
    localparam int unsigned WORD_CNT_W   = $clog2(SECTOR_WORDS) + 1;
    localparam int unsigned USEDW_W      = 12;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_POP_L = 3'd1,
        ST_POP_R = 3'd2,
        ST_SCALE = 3'd3,
        ST_OUT   = 3'd4
    } rd_state_t;

    typedef struct packed {
        logic [SAMPLE_W-1:0] l;
        logic [SAMPLE_W-1:0] r;
    } stereo_t;

endpackage

// File: rtl/msu_audio_sample_fifo.sv
// ---------------------------------------------------------------------------
// msu_audio_sample_fifo
// Purpose : single-clock show-ahead FIFO holding 16-bit PCM words.
// Ports   : clk, rst        - clock, async active-high reset
//           i_clear         - synchronous empty; overrides write and read
//           i_wr / i_din    - write request and data (dropped when full)
//           i_rd            - pop request (ignored when empty)
//           o_q_c           - word at the head of the FIFO (combinational)
//           o_usedw         - registered occupancy in words
//           o_full_c        - occupancy equals DEPTH
//           o_empty_c       - occupancy is zero
// ---------------------------------------------------------------------------
module msu_audio_sample_fifo #(
    parameter int unsigned DEPTH   = 2048,
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned USEDW_W = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_clear,
    input  logic               i_wr,
    input  logic [WIDTH-1:0]   i_din,
    input  logic               i_rd,
    output logic [WIDTH-1:0]   o_q_c,
    output logic [USEDW_W-1:0] o_usedw,
    output logic               o_full_c,
    output logic               o_empty_c
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [USEDW_W-1:0] r_count;
    logic               w_wr_ok;
    logic               w_rd_ok;
    logic [AW-1:0]      w_wr_ptr_nxt;
    logic [AW-1:0]      w_rd_ptr_nxt;

    assign o_full_c  = (r_count == USEDW_W'(DEPTH));
    assign o_empty_c = (r_count == '0);
    assign o_usedw   = r_count;
    assign o_q_c     = r_mem[r_rd_ptr];

    assign w_wr_ok = i_wr & ~o_full_c & ~i_clear;
    assign w_rd_ok = i_rd & ~o_empty_c & ~i_clear;

    // Pointer wrap written out so non-power-of-two depths also work.
    assign w_wr_ptr_nxt = (r_wr_ptr == AW'(DEPTH - 1)) ? '0 : r_wr_ptr + AW'(1);
    assign w_rd_ptr_nxt = (r_rd_ptr == AW'(DEPTH - 1)) ? '0 : r_rd_ptr + AW'(1);

    // Storage array, no reset needed.
    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    // Pointers and occupancy; simultaneous write and read leave count unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_ok) begin
                r_wr_ptr <= w_wr_ptr_nxt;
            end
            if (w_rd_ok) begin
                r_rd_ptr <= w_rd_ptr_nxt;
            end
            case ({w_wr_ok, w_rd_ok})
                2'b10:   r_count <= r_count + USEDW_W'(1);
                2'b01:   r_count <= r_count - USEDW_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/msu_audio_fifo.sv
// ---------------------------------------------------------------------------
// msu_audio_fifo
// Purpose : buffers PCM words streamed from the SD sector buffer and plays
//           them out as stereo frames at SAMPLE_HZ.
// Config  : define MSU_AUDIO_VOLUME_EN to apply the 8-bit linear volume;
//           otherwise samples pass through unscaled and volume is ignored.
// Ports   : clk, reset            - clock, async active-high reset
//           trackmounting, flush  - empty the FIFO and restart L/R pairing
//           sd_ack_1, sd_buff_wr,
//           sd_buff_dout, sd_lba_1,
//           ignore_sd_buffer_out  - SD sector-buffer write side
//           audio_play, volume    - playback enable and volume
//           audio_fifo_usedw      - FIFO occupancy in words
//           audio_l, audio_r      - signed output samples
//           sample_strobe         - pulse when audio_l/audio_r update
//           underrun              - pulse when a frame was due but < 2 words
//           overflow              - sticky, a write was dropped on full
// ---------------------------------------------------------------------------
module msu_audio_fifo
    import msu_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 21477270,
    parameter int unsigned SAMPLE_HZ  = 44100,
    parameter int unsigned FIFO_DEPTH = 2048
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                trackmounting,
    input  logic                flush,
    input  logic                sd_ack_1,
    input  logic                sd_buff_wr,
    input  logic [15:0]         sd_buff_dout,
    input  logic [20:0]         sd_lba_1,
    input  logic                ignore_sd_buffer_out,
    input  logic                audio_play,
    input  logic [7:0]          volume,
    output logic [USEDW_W-1:0]  audio_fifo_usedw,
    output logic [15:0]         audio_l,
    output logic [15:0]         audio_r,
    output logic                sample_strobe,
    output logic                underrun,
    output logic                overflow
);

    localparam int unsigned ACC_W = 32;

    logic                  w_clear;
    logic                  r_ack_d;
    logic                  w_ack_rise;
    logic [WORD_CNT_W-1:0] r_word_cnt;
    logic [WORD_CNT_W-1:0] w_word_idx;
    logic                  w_hdr;
    logic                  w_wr_req;

    logic [ACC_W-1:0]      r_acc;
    logic [ACC_W-1:0]      w_acc_sum;
    logic                  w_tick;

    logic [SAMPLE_W-1:0]   w_fifo_q;
    logic [USEDW_W-1:0]    w_usedw;
    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic                  w_have_pair;

    rd_state_t             r_state;
    rd_state_t             w_state_nxt;
    logic                  w_pop;
    logic                  w_cap_l;
    logic                  w_cap_r;
    logic                  w_load;
    logic                  w_zero;
    logic                  w_underrun_ev;

    stereo_t               r_pair;
    stereo_t               w_scaled;

    logic [15:0]           r_audio_l;
    logic [15:0]           r_audio_r;
    logic                  r_strobe;
    logic                  r_underrun;
    logic                  r_overflow;

    assign w_clear = flush | trackmounting;

    // Word-in-sector index: the word arriving on the ack rising edge is word 0.
    assign w_ack_rise = sd_ack_1 & ~r_ack_d;
    assign w_word_idx = w_ack_rise ? '0 : r_word_cnt;
    assign w_hdr      = (sd_lba_1 == '0) && (w_word_idx < WORD_CNT_W'(HDR_WORDS));
    assign w_wr_req   = sd_ack_1 & sd_buff_wr & ~ignore_sd_buffer_out & ~w_hdr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ack_d    <= 1'b0;
            r_word_cnt <= '0;
        end else begin
            r_ack_d <= sd_ack_1;
            if (sd_ack_1) begin
                r_word_cnt <= w_word_idx + WORD_CNT_W'(sd_buff_wr);
            end
        end
    end

    // Fractional rate generator; free-running whether or not audio plays.
    assign w_acc_sum = r_acc + ACC_W'(SAMPLE_HZ);
    assign w_tick    = (w_acc_sum >= ACC_W'(CLK_HZ));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc <= '0;
        end else if (w_tick) begin
            r_acc <= w_acc_sum - ACC_W'(CLK_HZ);
        end else begin
            r_acc <= w_acc_sum;
        end
    end

    msu_audio_sample_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .WIDTH   (SAMPLE_W),
        .USEDW_W (USEDW_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (reset),
        .i_clear   (w_clear),
        .i_wr      (w_wr_req),
        .i_din     (sd_buff_dout),
        .i_rd      (w_pop),
        .o_q_c     (w_fifo_q),
        .o_usedw   (w_usedw),
        .o_full_c  (w_fifo_full),
        .o_empty_c (w_fifo_empty)
    );

    assign w_have_pair = (w_usedw >= USEDW_W'(2));

    // Overflow stays set until the FIFO is explicitly emptied.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (w_clear) begin
            r_overflow <= 1'b0;
        end else if (w_wr_req && w_fifo_full) begin
            r_overflow <= 1'b1;
        end
    end

    // Read FSM: state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Read FSM: next state; ticks outside IDLE are dropped.
    always_comb begin
        w_state_nxt = r_state;
        if (w_clear) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:  if (w_tick && audio_play && w_have_pair) w_state_nxt = ST_POP_L;
                ST_POP_L: w_state_nxt = ST_POP_R;
                ST_POP_R: w_state_nxt = ST_SCALE;
                ST_SCALE: w_state_nxt = ST_OUT;
                ST_OUT:   w_state_nxt = ST_IDLE;
                default:  w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Read FSM: per-state actions. Outputs are loaded leaving SCALE so the
    // strobe is visible during OUT, four clocks after the tick.
    always_comb begin
        w_pop         = 1'b0;
        w_cap_l       = 1'b0;
        w_cap_r       = 1'b0;
        w_load        = 1'b0;
        w_zero        = 1'b0;
        w_underrun_ev = 1'b0;
        if (!w_clear) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_tick) begin
                        if (!audio_play) begin
                            w_zero = 1'b1;
                        end else if (!w_have_pair) begin
                            w_underrun_ev = 1'b1;
                        end
                    end
                end
                ST_POP_L: begin
                    w_pop   = 1'b1;
                    w_cap_l = 1'b1;
                end
                ST_POP_R: begin
                    w_pop   = 1'b1;
                    w_cap_r = 1'b1;
                end
                ST_SCALE: w_load = 1'b1;
                default: ;
            endcase
        end
    end

    // Holding register for the frame being assembled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pair <= '0;
        end else begin
            if (w_cap_l) begin
                r_pair.l <= w_fifo_q;
            end
            if (w_cap_r) begin
                r_pair.r <= w_fifo_q;
            end
        end
    end

`ifdef MSU_AUDIO_VOLUME_EN
    // Signed sample x unsigned volume; the 24-bit modular product is exact
    // because both operands are extended before the multiply.
    logic [23:0] w_vol_ext;
    logic [23:0] w_prod_l;
    logic [23:0] w_prod_r;

    assign w_vol_ext  = 24'(volume);
    assign w_prod_l   = 24'($signed(r_pair.l)) * w_vol_ext;
    assign w_prod_r   = 24'($signed(r_pair.r)) * w_vol_ext;
    assign w_scaled.l = w_prod_l[23:8];
    assign w_scaled.r = w_prod_r[23:8];
`else
    logic w_unused_volume;

    assign w_unused_volume = ^volume;
    assign w_scaled        = r_pair;
`endif

    // Registered output stage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_audio_l  <= '0;
            r_audio_r  <= '0;
            r_strobe   <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_strobe   <= w_load | w_zero;
            r_underrun <= w_underrun_ev;
            if (w_load) begin
                r_audio_l <= w_scaled.l;
                r_audio_r <= w_scaled.r;
            end else if (w_zero) begin
                r_audio_l <= '0;
                r_audio_r <= '0;
            end
        end
    end

    assign audio_fifo_usedw = w_usedw;
    assign audio_l          = r_audio_l;
    assign audio_r          = r_audio_r;
    assign sample_strobe    = r_strobe;
    assign underrun         = r_underrun;
    assign overflow         = r_overflow;

endmodule
